// File: rtl/fifos_interface_pkg.sv
// Shared sizing constants and word layout for the request/response FIFO pair.
package fifos_interface_pkg;

  localparam int FIFO_DEPTH         = 32;
  localparam int LOG2_FIFO_DEPTH    = 5;
  localparam int DATA_LINE_WIDTH    = 64;
  localparam int CONTROL_LINE_WIDTH = 6;

  // Full word carried through each FIFO: control in the upper bits, data below.
  localparam int W = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;

  typedef logic [CONTROL_LINE_WIDTH-1:0] control_t;
  typedef logic [DATA_LINE_WIDTH-1:0]    data_t;
  typedef logic [W-1:0]                  word_t;

  typedef struct packed {
    control_t control;
    data_t    data;
  } word_fields_t;

  // Build a packed word from its control and data fields.
  function automatic word_t pack_word(input control_t control, input data_t data);
    word_fields_t f;
    f.control = control;
    f.data    = data;
    return word_t'(f);
  endfunction

  // Extract the control field of a packed word.
  function automatic control_t word_control(input word_t word);
    word_fields_t f;
    f = word_fields_t'(word);
    return f.control;
  endfunction

  // Extract the data field of a packed word.
  function automatic data_t word_data(input word_t word);
    word_fields_t f;
    f = word_fields_t'(word);
    return f.data;
  endfunction

endpackage

// File: rtl/fifos_interface_if.sv
// Bundle of the request and response channel signals shared between the
// controllers and the FIFO block. The master modport is the controller side
// (drives writes/read enables), the slave modport is the FIFO block side.
interface fifos_interface_if;
  import fifos_interface_pkg::*;

  // Request channel: master writes, slave reads
  word_t i_mc_sreq_inbits;
  logic  i_mc_sreq_wen;
  logic  o_mc_sreq_fifo_empty;
  logic  o_mc_sreq_fifo_full;
  logic  i_sc_rreq_ren;
  word_t o_sc_rreq_outbits;

  // Response channel: slave writes, master reads
  word_t i_sc_sresp_inbits;
  logic  i_sc_sresp_wen;
  logic  o_sc_sresp_fifo_empty;
  logic  o_sc_sresp_fifo_full;
  logic  i_mc_rresp_ren;
  word_t o_mc_rresp_outbits;

  modport master (
    output i_mc_sreq_inbits,
    output i_mc_sreq_wen,
    input  o_mc_sreq_fifo_empty,
    input  o_mc_sreq_fifo_full,
    output i_sc_rreq_ren,
    input  o_sc_rreq_outbits,
    output i_sc_sresp_inbits,
    output i_sc_sresp_wen,
    input  o_sc_sresp_fifo_empty,
    input  o_sc_sresp_fifo_full,
    output i_mc_rresp_ren,
    input  o_mc_rresp_outbits
  );

  modport slave (
    input  i_mc_sreq_inbits,
    input  i_mc_sreq_wen,
    output o_mc_sreq_fifo_empty,
    output o_mc_sreq_fifo_full,
    input  i_sc_rreq_ren,
    output o_sc_rreq_outbits,
    input  i_sc_sresp_inbits,
    input  i_sc_sresp_wen,
    output o_sc_sresp_fifo_empty,
    output o_sc_sresp_fifo_full,
    input  i_mc_rresp_ren,
    output o_mc_rresp_outbits
  );

endinterface

// File: rtl/fifos_interface_sync_fifo.sv
// Single-clock FIFO with registered read data and registered empty/full flags.
// Writes while full and reads while empty are ignored, so the FIFO can never
// overflow or underflow. The occupancy count is one bit wider than the
// pointers so that full and empty are distinguishable.
module sync_fifo
  import fifos_interface_pkg::*;
#(
  parameter int WIDTH  = W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = LOG2_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] inbits,
  input  logic             ren,
  output logic [WIDTH-1:0] outbits,
  output logic             empty,
  output logic             full
);

  localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;
  logic              do_write;
  logic              do_read;

  // Operations are qualified by the flags as they stand before the edge.
  assign do_write = wen && !full;
  assign do_read  = ren && !empty;

  // Next occupancy: up on write-only, down on read-only, else unchanged.
  always_comb begin
    count_next = count;
    if (do_write && !do_read) begin
      count_next = count + 1'b1;
    end else if (do_read && !do_write) begin
      count_next = count - 1'b1;
    end
  end

  // Storage array; contents are don't-care after reset so it has no reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= inbits;
    end
  end

  // Pointers roll over naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Count and flags are updated together from the next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == COUNT_FULL);
    end
  end

  // Registered read port: one cycle latency, holds value when no read occurs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outbits <= '0;
    end else if (do_read) begin
      outbits <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/fifos_interface.sv
// Two independent FIFOs between the master controller and slave controller:
// the request FIFO carries master-to-slave words, the response FIFO carries
// slave-to-master words. The two channels share only the clock and reset.
module fifos_interface
  import fifos_interface_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fifos_interface_if.slave   bus
);

  // Request channel: written by the master, drained by the slave.
  sync_fifo #(
    .WIDTH  (W),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (LOG2_FIFO_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .wen     (bus.i_mc_sreq_wen),
    .inbits  (bus.i_mc_sreq_inbits),
    .ren     (bus.i_sc_rreq_ren),
    .outbits (bus.o_sc_rreq_outbits),
    .empty   (bus.o_mc_sreq_fifo_empty),
    .full    (bus.o_mc_sreq_fifo_full)
  );

  // Response channel: written by the slave, drained by the master.
  sync_fifo #(
    .WIDTH  (W),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (LOG2_FIFO_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .wen     (bus.i_sc_sresp_wen),
    .inbits  (bus.i_sc_sresp_inbits),
    .ren     (bus.i_mc_rresp_ren),
    .outbits (bus.o_mc_rresp_outbits),
    .empty   (bus.o_sc_sresp_fifo_empty),
    .full    (bus.o_sc_sresp_fifo_full)
  );

endmodule

// File: tb/tb_fifos_interface.sv
// Directed testbench for the request/response FIFO pair.
module tb_fifos_interface;
  import fifos_interface_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fifos_interface_if bus();

  fifos_interface dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive both channels for one clock, then wait until just after the edge.
  task automatic applyStimulus(input logic req_wen, input logic req_ren,
                               input logic [W-1:0] req_in,
                               input logic rsp_wen, input logic rsp_ren,
                               input logic [W-1:0] rsp_in);
    bus.i_mc_sreq_wen    = req_wen;
    bus.i_sc_rreq_ren    = req_ren;
    bus.i_mc_sreq_inbits = req_in;
    bus.i_sc_sresp_wen   = rsp_wen;
    bus.i_mc_rresp_ren   = rsp_ren;
    bus.i_sc_sresp_inbits = rsp_in;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.i_mc_sreq_wen = 1'b0;
    bus.i_sc_rreq_ren = 1'b0;
    bus.i_mc_sreq_inbits = '0;
    bus.i_sc_sresp_wen = 1'b0;
    bus.i_mc_rresp_ren = 1'b0;
    bus.i_sc_sresp_inbits = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // Reset state
    checkOutput("rst_req_empty", W'(bus.o_mc_sreq_fifo_empty), W'(1));
    checkOutput("rst_req_full", W'(bus.o_mc_sreq_fifo_full), W'(0));
    checkOutput("rst_req_out", bus.o_sc_rreq_outbits, W'(0));
    checkOutput("rst_rsp_empty", W'(bus.o_sc_sresp_fifo_empty), W'(1));
    checkOutput("rst_rsp_full", W'(bus.o_sc_sresp_fifo_full), W'(0));
    checkOutput("rst_rsp_out", bus.o_mc_rresp_outbits, W'(0));
    rst = 1'b0;
    idle();

    // Overflow: 70 writes, only the first 32 are kept
    for (int i = 0; i < 70; i++) begin
      applyStimulus(1'b1, 1'b0, W'(i), 1'b0, 1'b0, '0);
      checkOutput($sformatf("ovf_empty_%0d", i), W'(bus.o_mc_sreq_fifo_empty), W'(0));
      checkOutput($sformatf("ovf_full_%0d", i), W'(bus.o_mc_sreq_fifo_full),
                  W'(i >= 31));
    end
    checkOutput("ovf_rsp_empty", W'(bus.o_sc_sresp_fifo_empty), W'(1));

    // Underflow: 70 reads, data 0..31 then held
    for (int i = 0; i < 70; i++) begin
      applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
      checkOutput($sformatf("unf_out_%0d", i), bus.o_sc_rreq_outbits,
                  W'((i < 32) ? i : 31));
      checkOutput($sformatf("unf_empty_%0d", i), W'(bus.o_mc_sreq_fifo_empty),
                  W'(i >= 31));
      checkOutput($sformatf("unf_full_%0d", i), W'(bus.o_mc_sreq_fifo_full), W'(0));
    end

    // Response FIFO: write 70..139, keeps 70..101
    for (int i = 0; i < 70; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, W'(70 + i));
      checkOutput($sformatf("rsp_wr_req_empty_%0d", i), W'(bus.o_mc_sreq_fifo_empty), W'(1));
    end
    checkOutput("rsp_full", W'(bus.o_sc_sresp_fifo_full), W'(1));
    checkOutput("rsp_req_full", W'(bus.o_mc_sreq_fifo_full), W'(0));
    for (int i = 0; i < 70; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
      checkOutput($sformatf("rsp_out_%0d", i), bus.o_mc_rresp_outbits,
                  W'((i < 32) ? (70 + i) : 101));
      checkOutput($sformatf("rsp_rd_req_empty_%0d", i), W'(bus.o_mc_sreq_fifo_empty), W'(1));
    end
    checkOutput("rsp_empty_end", W'(bus.o_sc_sresp_fifo_empty), W'(1));
    checkOutput("rsp_req_out_held", bus.o_sc_rreq_outbits, W'(31));

    // Wrap-around: write 20, read 20, then a full set across the wrap
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, W'(32'h200 + i), 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
      checkOutput($sformatf("wrap_pre_%0d", i), bus.o_sc_rreq_outbits, W'(32'h200 + i));
    end
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, W'(32'h100 + i), 1'b0, 1'b0, '0);
    checkOutput("wrap_full", W'(bus.o_mc_sreq_fifo_full), W'(1));
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
      checkOutput($sformatf("wrap_out_%0d", i), bus.o_sc_rreq_outbits, W'(32'h100 + i));
    end
    checkOutput("wrap_empty", W'(bus.o_mc_sreq_fifo_empty), W'(1));

    // Simultaneous read/write while full: read happens, write is lost
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, W'(32'h300 + i), 1'b0, 1'b0, '0);
    checkOutput("simf_full_before", W'(bus.o_mc_sreq_fifo_full), W'(1));
    applyStimulus(1'b1, 1'b1, W'(32'hDEAD), 1'b0, 1'b0, '0);
    checkOutput("simf_out", bus.o_sc_rreq_outbits, W'(32'h300));
    checkOutput("simf_full", W'(bus.o_mc_sreq_fifo_full), W'(0));
    checkOutput("simf_empty", W'(bus.o_mc_sreq_fifo_empty), W'(0));
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
      checkOutput($sformatf("simf_drain_%0d", i), bus.o_sc_rreq_outbits, W'(32'h300 + i));
      checkOutput($sformatf("simf_drain_empty_%0d", i), W'(bus.o_mc_sreq_fifo_empty),
                  W'(i == 31));
    end
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
    checkOutput("simf_no_extra", bus.o_sc_rreq_outbits, W'(32'h31F));

    // Simultaneous read/write while empty: write happens, read ignored
    applyStimulus(1'b1, 1'b1, W'(32'h400), 1'b0, 1'b0, '0);
    checkOutput("sime_empty", W'(bus.o_mc_sreq_fifo_empty), W'(0));
    checkOutput("sime_out_held", bus.o_sc_rreq_outbits, W'(32'h31F));
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
    checkOutput("sime_out", bus.o_sc_rreq_outbits, W'(32'h400));
    checkOutput("sime_empty_after", W'(bus.o_mc_sreq_fifo_empty), W'(1));

    // Reset mid-operation, asserted between clock edges
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, W'(32'h500 + i), 1'b0, 1'b0, '0);
    bus.i_mc_sreq_wen = 1'b0;
    checkOutput("mid_empty_before", W'(bus.o_mc_sreq_fifo_empty), W'(0));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_empty", W'(bus.o_mc_sreq_fifo_empty), W'(1));
    checkOutput("mid_rst_full", W'(bus.o_mc_sreq_fifo_full), W'(0));
    checkOutput("mid_rst_out", bus.o_sc_rreq_outbits, W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
      checkOutput($sformatf("post_rst_out_%0d", i), bus.o_sc_rreq_outbits, W'(0));
      checkOutput($sformatf("post_rst_empty_%0d", i), W'(bus.o_mc_sreq_fifo_empty), W'(1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
